reduction_arbiter: RTL and testbench
====================================

REDUCTION_ARBITER -- requirements
Module: reduction_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: there is one clock, and reset is asynchronous and active-high.
REQ-002 The parameter NREQ SHALL default to 4 and sets the number of requesters.
REQ-003 The parameter LAT SHALL default to 3 and is the clock-edge latency of the shared reduction unit from red_in/red_qsel to red_out.
REQ-004 Port clk  input  1  is the single clock.
REQ-005 Port rst  input  1  is the asynchronous, active-high reset.
REQ-006 Port req_valid  input  NREQ  carries the per-requester request valid.
REQ-007 Port req_data  input  60*NREQ  carries the 60-bit operands; requester i uses bits [60i+59:60i].
REQ-008 Port req_qsel  input  4*NREQ  carries the modulus index per requester, valid range 0..12.
REQ-009 Port req_ready  output  NREQ  is the one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 Port red_in  output  60  drives the operand to the shared reduction unit.
REQ-011 Port red_qsel  output  4  drives the modulus index to the shared reduction unit.
REQ-012 Port red_out  input  30  returns the reduced result from the shared reduction unit.
REQ-013 Port rsp_valid  output  NREQ  is a one-cycle response pulse, one-hot, per requester.
REQ-014 Port rsp_data  output  30  carries the response value.
REQ-015 Port rsp_err  output  1  flags an invalid q_sel and is qualified by any rsp_valid bit.
REQ-016 Port inflight  output  3  gives the count of accepted requests not yet responded.
REQ-017 Port busy  output  1  indicates that inflight is nonzero or any req_valid bit is high.

Function
REQ-018 Arbitration SHALL be round-robin: the grant goes to the first i with req_valid[i]=1, searching from index ptr upward and wrapping modulo NREQ.
REQ-019 req_ready SHALL be combinational from req_valid and ptr, with at most one bit high and no grant when req_valid=0.
REQ-020 On a handshake with requester g, ptr SHALL update to (g+1) mod NREQ; with no handshake, ptr SHALL hold.
REQ-021 The block SHALL accept at most one request per cycle and SHALL sustain a throughput of one per cycle under back-to-back load.
REQ-022 red_in and red_qsel SHALL be registered and loaded at the handshake edge E0 with the granted req_data and req_qsel.
REQ-023 red_in and red_qsel SHALL be loaded with zero on any edge with no valid issue.
REQ-024 A request with req_qsel>12 SHALL be accepted normally, SHALL drive red_in=0 and red_qsel=0, and SHALL be marked err in the tag pipe.
REQ-025 A tag pipe of LAT+1 stages SHALL carry {valid, requester id, err} and SHALL advance every cycle with no stall.
REQ-026 rsp_valid, rsp_data and rsp_err SHALL be registered, capturing red_out at edge E0+LAT+1, so the response is visible in the cycle after E0+LAT+1 (four edges after acceptance for LAT=3).
REQ-027 On a response, exactly one rsp_valid bit SHALL be set, at the tag id, and rsp_data SHALL equal red_out, or 0 when err=1.
REQ-028 When no response is due, rsp_valid SHALL be 0 while rsp_data and rsp_err SHALL hold their last values.
REQ-029 Response order SHALL equal acceptance order; the block applies no backpressure on responses.
REQ-030 inflight SHALL increment on acceptance and decrement on a response; when both occur in the same cycle it SHALL be unchanged.
REQ-031 inflight SHALL never exceed LAT+1.
REQ-032 A request that is not granted SHALL keep its req_valid, req_data and req_qsel stable until granted; the block does not check this.

Reset
REQ-033 While rst=1, the block SHALL hold req_ready=0 and ptr=0.
REQ-034 rst SHALL immediately clear the tag pipe, inflight, red_in, red_qsel, rsp_valid, rsp_data and rsp_err to 0, with no clock edge required.
REQ-035 A reset asserted mid-operation SHALL discard all in-flight requests, and no responses for them SHALL ever appear.
REQ-036 The first grant after rst deasserts SHALL follow round-robin from ptr=0.

Verification
REQ-037 Single request: req0 data=2^30 (1073741824), qsel=0 (q=1068564481), accepted at edge E0 -> rsp_valid=0001 in the cycle after E0+4, rsp_data=5177343, rsp_err=0.
REQ-038 Continuous contention: req_valid=1111 held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one per cycle, with responses in the same order and inflight saturating at 4.
REQ-039 Invalid modulus: req2 with qsel=13 -> accepted, red_in=0 and red_qsel=0 on the next cycle, then rsp_valid=0100, rsp_err=1, rsp_data=0 four edges after acceptance.
REQ-040 Pointer skip: ptr=1 with req_valid=1001 -> grant 3, then ptr=0 -> grant 0 next cycle.
REQ-041 Reset mid-flight: 3 requests accepted, rst pulsed between edges before any response -> all outputs 0 immediately, inflight=0, and no rsp_valid for the 3 requests afterwards.
REQ-042 Simultaneous accept and respond: a steady single requester issuing every cycle -> inflight stays 4 while rsp_valid pulses every cycle with rsp_data equal to the corresponding red_out.

Source files
------------

// File: rtl/reduction_arbiter.sv
// Round-robin front end for a shared, fixed-latency modular reduction unit.
// It issues one operand per cycle and routes each result back to the requester that sent it.
module reduction_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [60*NREQ-1:0]   req_data,
  input  logic [4*NREQ-1:0]    req_qsel,
  output logic [NREQ-1:0]      req_ready,
  output logic [59:0]          red_in,
  output logic [3:0]           red_qsel,
  input  logic [29:0]          red_out,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [29:0]          rsp_data,
  output logic                 rsp_err,
  output logic [2:0]           inflight,
  output logic                 busy
);

  localparam int unsigned DW   = 60;
  localparam int unsigned QW   = 4;
  localparam int unsigned RW   = 30;
  localparam int unsigned CW   = 3;
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned QMAX = 12;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] id;
    logic          err;
  } tag_t;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [2*NREQ-1:0] dbl_c;
  logic [NREQ-1:0]   rot_c;
  logic [PW-1:0]     off_c;
  logic [PW:0]       sum_c;
  logic [PW-1:0]     gnt_id_c;
  logic              hs_c;
  logic [QW-1:0]     qsel_c;
  logic              err_c;
  logic [DW-1:0]     red_in_q, red_in_d;
  logic [QW-1:0]     red_qsel_q, red_qsel_d;
  tag_t              tag_q [LAT+1];
  tag_t              tag_d;
  logic              rsp_due_c;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [RW-1:0]     rsp_data_q;
  logic              rsp_err_q;
  logic [CW-1:0]     inflight_q, inflight_d;

  // Rotate requests so that index 0 is the current pointer, pick the lowest set bit.
  always_comb begin
    dbl_c    = {req_valid, req_valid} >> ptr_q;
    rot_c    = dbl_c[NREQ-1:0];
    off_c    = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (rot_c[k]) off_c = PW'(k);
    end
    sum_c    = (PW+1)'(ptr_q) + (PW+1)'(off_c);
    if (sum_c >= (PW+1)'(NREQ)) sum_c = sum_c - (PW+1)'(NREQ);
    gnt_id_c = PW'(sum_c);
    hs_c     = (|req_valid) && !rst;
    req_ready = '0;
    if (hs_c) req_ready[gnt_id_c] = 1'b1;
  end

  always_comb begin
    qsel_c     = req_qsel[gnt_id_c*QW +: QW];
    err_c      = qsel_c > QW'(QMAX);
    red_in_d   = '0;
    red_qsel_d = '0;
    if (hs_c && !err_c) begin
      red_in_d   = req_data[gnt_id_c*DW +: DW];
      red_qsel_d = qsel_c;
    end
    tag_d      = '{vld: hs_c, id: gnt_id_c, err: hs_c && err_c};
    ptr_d      = (gnt_id_c == PW'(NREQ - 1)) ? '0 : gnt_id_c + PW'(1);
  end

  assign rsp_due_c = tag_q[LAT].vld;

  always_comb begin
    inflight_d = inflight_q;
    if (hs_c && !rsp_due_c)      inflight_d = inflight_q + CW'(1);
    else if (!hs_c && rsp_due_c) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      red_in_q   <= '0;
      red_qsel_q <= '0;
      inflight_q <= '0;
      for (int unsigned k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      if (hs_c) ptr_q <= ptr_d;
      red_in_q   <= red_in_d;
      red_qsel_q <= red_qsel_d;
      inflight_q <= inflight_d;
      tag_q[0]   <= tag_d;
      for (int unsigned k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Results line up with the last tag stage; data and err hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (rsp_due_c) begin
      rsp_valid_q <= NREQ'(1) << tag_q[LAT].id;
      rsp_data_q  <= tag_q[LAT].err ? '0 : red_out;
      rsp_err_q   <= tag_q[LAT].err;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  assign red_in    = red_in_q;
  assign red_qsel  = red_qsel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign inflight  = inflight_q;
  assign busy      = (|inflight_q) || (|req_valid);

endmodule

// File: tb/tb_reduction_arbiter.sv
// Directed bench for reduction_arbiter with a behavioural 3-cycle reduction unit model.
module tb_reduction_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [60*NREQ-1:0]  req_data;
  logic [4*NREQ-1:0]   req_qsel;
  logic [NREQ-1:0]     req_ready;
  logic [59:0]         red_in;
  logic [3:0]          red_qsel;
  logic [29:0]         red_out;
  logic [NREQ-1:0]     rsp_valid;
  logic [29:0]         rsp_data;
  logic                rsp_err;
  logic [2:0]          inflight;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  logic [NREQ-1:0] rv_log [$];
  logic [29:0]     rd_log [$];
  int              g_log  [$];
  int              max_infl = 0;

  reduction_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_qsel(req_qsel),
    .req_ready(req_ready),
    .red_in(red_in), .red_qsel(red_qsel), .red_out(red_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model of the external reduction unit: qsel 0 is q=1068564481.
  function automatic logic [29:0] reduce(input logic [59:0] x, input logic [3:0] s);
    logic [63:0] q;
    q = 64'd1068564481 - 64'(s) * 64'd1000;
    return 30'(64'(x) % q);
  endfunction

  logic [29:0] red_pipe [LAT];
  always @(posedge clk) begin
    red_pipe[0] <= reduce(red_in, red_qsel);
    for (int k = 1; k < int'(LAT); k++) red_pipe[k] <= red_pipe[k-1];
  end
  assign red_out = red_pipe[LAT-1];

  // Values seen during the cycle that ends at this edge.
  always @(posedge clk) begin
    if (|rsp_valid) begin
      rv_log.push_back(rsp_valid);
      rd_log.push_back(rsp_data);
    end
    for (int i = 0; i < int'(NREQ); i++)
      if (req_valid[i] && req_ready[i]) g_log.push_back(i);
    if (int'(inflight) > max_infl) max_infl = int'(inflight);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [59:0] d, input logic [3:0] q);
    req_data[i*60 +: 60] = d;
    req_qsel[i*4 +: 4]   = q;
  endtask

  task automatic clear_logs();
    rv_log.delete();
    rd_log.delete();
    g_log.delete();
    max_infl = 0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_qsel  = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset holds off grants and clears state.
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_red_in", 64'(red_in), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single request, 2^30 mod q0.
    set_req(0, 60'd1073741824, 4'd0);
    req_valid = 4'b0001;
    #1 check("single_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    check("single_red_in", 64'(red_in), 64'd1073741824);
    check("single_red_qsel", 64'(red_qsel), 64'd0);
    check("single_inflight", 64'(inflight), 64'd1);
    step(); step(); step();
    check("single_early", 64'(rsp_valid), 64'd0);
    step();
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_data", 64'(rsp_data), 64'd5177343);
    check("single_rsp_err", 64'(rsp_err), 64'd0);
    check("single_inflight0", 64'(inflight), 64'd0);
    step();
    check("single_pulse", 64'(rsp_valid), 64'd0);
    check("single_hold", 64'(rsp_data), 64'd5177343);
    check("idle_busy", 64'(busy), 64'd0);

    // Pointer skip from ptr=1 with 1001.
    clear_logs();
    set_req(3, 60'd12345, 4'd0);
    set_req(0, 60'd2147483648, 4'd0);
    req_valid = 4'b1001;
    #1 check("skip_ready3", 64'(req_ready), 64'b1000);
    step();
    #1 check("skip_ready0", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    repeat (6) step();
    check("skip_nrsp", 64'(rv_log.size()), 64'd2);
    if (rv_log.size() == 2) begin
      check("skip_rsp0_v", 64'(rv_log[0]), 64'b1000);
      check("skip_rsp0_d", 64'(rd_log[0]), 64'd12345);
      check("skip_rsp1_v", 64'(rv_log[1]), 64'b0001);
      check("skip_rsp1_d", 64'(rd_log[1]), 64'd10354686);
    end

    // Invalid modulus on requester 2.
    set_req(2, 60'd555, 4'd13);
    req_valid = 4'b0100;
    #1 check("bad_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    check("bad_red_in", 64'(red_in), 64'd0);
    check("bad_red_qsel", 64'(red_qsel), 64'd0);
    check("bad_inflight", 64'(inflight), 64'd1);
    step(); step(); step();
    check("bad_early", 64'(rsp_valid), 64'd0);
    step();
    check("bad_rsp_valid", 64'(rsp_valid), 64'b0100);
    check("bad_rsp_err", 64'(rsp_err), 64'd1);
    check("bad_rsp_data", 64'(rsp_data), 64'd0);
    step();

    // Reset mid-flight after three acceptances.
    clear_logs();
    set_req(0, 60'd11, 4'd0);
    set_req(1, 60'd22, 4'd0);
    set_req(2, 60'd33, 4'd0);
    req_valid = 4'b0111;
    step(); step(); step();
    req_valid = '0;
    check("mid_inflight", 64'(inflight), 64'd3);
    check("mid_red_in", 64'(red_in), 64'd33);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_red_in", 64'(red_in), 64'd0);
    check("mid_rst_inflight", 64'(inflight), 64'd0);
    check("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    #1 rst = 1'b0;
    repeat (8) step();
    check("mid_no_rsp", 64'(rv_log.size()), 64'd0);

    // Full contention after reset: 0,1,2,3,0,1,2,3.
    clear_logs();
    for (int i = 0; i < 4; i++) set_req(i, 60'(1000*i + 7), 4'd0);
    req_valid = 4'b1111;
    repeat (8) step();
    req_valid = '0;
    repeat (7) step();
    check("cont_ngrant", 64'(g_log.size()), 64'd8);
    check("cont_nrsp", 64'(rv_log.size()), 64'd8);
    if (g_log.size() == 8 && rv_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("cont_grant", 64'(g_log[i]), 64'(i % 4));
        check("cont_rsp_v", 64'(rv_log[i]), 64'(1 << (i % 4)));
        check("cont_rsp_d", 64'(rd_log[i]), 64'(1000*(i % 4) + 7));
      end
    end
    check("cont_max_infl", 64'(max_infl), 64'd4);

    // Steady single requester: accept and respond in the same cycle.
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      set_req(1, 60'(100 + k), 4'd0);
      req_valid = 4'b0010;
      step();
      check("steady_inflight", 64'(inflight), 64'((k + 1 < 4) ? k + 1 : 4));
    end
    req_valid = '0;
    repeat (7) step();
    check("steady_nrsp", 64'(rv_log.size()), 64'd10);
    if (rv_log.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        check("steady_rsp_v", 64'(rv_log[k]), 64'b0010);
        check("steady_rsp_d", 64'(rd_log[k]), 64'(100 + k));
      end
    end
    check("steady_end_infl", 64'(inflight), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
